// File: rtl/fp_mult_seq.sv
// Multi-cycle floating-point multiplier with parametric exponent/fraction widths.
// Shift-add significand datapath, round-to-nearest-even, special values and exception flags.
module fp_mult_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   c,
    output logic [3:0]             flags
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned XW = EXP_W + 2;
    localparam int unsigned CW = $clog2(MAN_W + 2);
    localparam logic signed [XW-1:0] Bias   = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] ExpMax = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {StIdle, StUnpack, StMult, StNorm, StRound} state_e;
    typedef enum logic [1:0] {SpNone, SpNan, SpInf, SpZero} spec_e;

    state_e                state_q, state_d;
    spec_e                 spec_q, spec_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic                  sign_q, sign_d;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic [SW-1:0]         ma_q, ma_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         man_q, man_d;
    logic                  guard_q, guard_d, sticky_q, sticky_d;
    logic [W-1:0]          c_q, c_d;
    logic [3:0]            flags_q, flags_d;
    logic                  done_q, done_d;

    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [SW:0]           acc;
    logic                  inc;
    logic [SW:0]           rnd;
    logic [MAN_W-1:0]      frac;
    logic signed [XW-1:0]  fe;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StUnpack;
            StUnpack: state_d = StMult;
            StMult:   if (cnt_q == CW'(MAN_W)) state_d = StNorm;
            StNorm:   state_d = StRound;
            StRound:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = (state_q != StIdle);
        done  = done_q;
        c     = c_q;
        flags = flags_q;
    end

    // Operand classification; subnormals (exp=0) count as zero.
    always_comb begin
        ea     = a_q[W-2 -: EXP_W];
        eb     = b_q[W-2 -: EXP_W];
        fa     = a_q[MAN_W-1:0];
        fb     = b_q[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
    end

    // Accumulate the high half and shift the product right: multiplier bits leave LSB first.
    assign acc = {1'b0, prod_q[PW-1:SW]} + (prod_q[0] ? {1'b0, ma_q} : '0);

    always_comb begin
        inc  = guard_q & (sticky_q | man_q[0]);
        rnd  = {1'b0, man_q} + {{SW{1'b0}}, inc};
        frac = rnd[SW] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        fe   = rnd[SW] ? exp_q + XW'(1) : exp_q;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        spec_d   = spec_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        ma_d     = ma_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        man_d    = man_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        c_d      = c_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d = a;
                    b_d = b;
                end
            end
            StUnpack: begin
                sign_d = a_q[W-1] ^ b_q[W-1];
                exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - Bias;
                ma_d   = {1'b1, fa};
                prod_d = {{SW{1'b0}}, 1'b1, fb};
                cnt_d  = '0;
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) spec_d = SpNan;
                else if (a_inf || b_inf)                                      spec_d = SpInf;
                else if (a_zero || b_zero)                                    spec_d = SpZero;
                else                                                          spec_d = SpNone;
            end
            StMult: begin
                prod_d = {acc, prod_q[SW-1:1]};
                cnt_d  = cnt_q + CW'(1);
            end
            StNorm: begin
                if (prod_q[PW-1]) begin
                    man_d    = prod_q[PW-1:SW];
                    guard_d  = prod_q[SW-1];
                    sticky_d = |prod_q[SW-2:0];
                    exp_d    = exp_q + XW'(1);
                end else begin
                    man_d    = prod_q[PW-2:SW-1];
                    guard_d  = prod_q[SW-2];
                    sticky_d = |prod_q[SW-3:0];
                end
            end
            StRound: begin
                done_d = 1'b1;
                unique case (spec_q)
                    SpNan: begin
                        c_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                        flags_d = 4'b1000;
                    end
                    SpInf: begin
                        c_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_d = 4'b0000;
                    end
                    SpZero: begin
                        c_d     = {sign_q, {(W-1){1'b0}}};
                        flags_d = 4'b0000;
                    end
                    default: begin
                        if (fe >= ExpMax) begin
                            c_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            flags_d = 4'b0101;
                        end else if (fe[XW-1] || (fe == '0)) begin
                            c_d     = {sign_q, {(W-1){1'b0}}};
                            flags_d = 4'b0011;
                        end else begin
                            c_d     = {sign_q, fe[EXP_W-1:0], frac};
                            flags_d = {3'b000, guard_q | sticky_q};
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q      <= '0;
            b_q      <= '0;
            spec_q   <= SpNone;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            ma_q     <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            man_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            c_q      <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            spec_q   <= spec_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            ma_q     <= ma_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            man_q    <= man_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            c_q      <= c_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed bench for fp_mult_seq: fp32 instance for the vector table and handshake/reset
// sequences, plus a half-precision-shaped instance (EXP_W=5, MAN_W=10).
module tb_fp_mult_seq;
    logic        clk;
    logic        rst;
    logic        start0, busy0, done0;
    logic [31:0] a0, b0, c0;
    logic [3:0]  flags0;
    logic        start1, busy1, done1;
    logic [15:0] a1, b1, c1;
    logic [3:0]  flags1;

    int total;
    int bad;

    fp_mult_seq #(.EXP_W(8), .MAN_W(23)) u_dut0 (
        .CLK(clk), .RST(rst), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .c(c0), .flags(flags0)
    );

    fp_mult_seq #(.EXP_W(5), .MAN_W(10)) u_dut1 (
        .CLK(clk), .RST(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .c(c1), .flags(flags1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    // Issue one op at the current negedge, wait for done; returns at the negedge of the done cycle.
    task automatic run_op(input bit sel, input string name, input logic [31:0] ta,
                          input logic [31:0] tb_, input int lat, input bit poke,
                          output logic [31:0] rc, output logic [3:0] rf);
        logic [31:0] c_init;
        logic        dn;
        bit          stable;
        int          n;
        if (!sel) begin
            start0 = 1'b1; a0 = ta; b0 = tb_;
        end else begin
            start1 = 1'b1; a1 = ta[15:0]; b1 = tb_[15:0];
        end
        c_init = sel ? {16'h0, c1} : c0;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        check({name, " busy_after_start"}, 32'(sel ? busy1 : busy0), 32'd1);
        stable = 1'b1;
        n = 0;
        do begin
            if (poke && n == 5) begin
                start0 = 1'b1; a0 = 32'h40400000; b0 = 32'h40400000;
            end else if (poke && n == 6) begin
                start0 = 1'b0;
            end
            @(negedge clk);
            n++;
            dn = sel ? done1 : done0;
            if (!dn && ((sel ? {16'h0, c1} : c0) !== c_init)) stable = 1'b0;
        end while (!dn && n < 100);
        start0 = 1'b0;
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " c_stable"}, 32'(stable), 32'd1);
        check({name, " busy_at_done"}, 32'(sel ? busy1 : busy0), 32'd0);
        rc = sel ? {16'h0, c1} : c0;
        rf = sel ? flags1 : flags0;
    endtask

    initial begin
        logic [31:0] rc;
        logic [3:0]  rf;
        bit          saw_done;

        total = 0;
        bad   = 0;
        vecs[0]  = '{"basic",      32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{"round",      32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        vecs[2]  = '{"zero_x_inf", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vecs[3]  = '{"ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[4]  = '{"overflow",   32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101};
        vecs[5]  = '{"underflow",  32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
        vecs[6]  = '{"nzero",      32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000};
        vecs[7]  = '{"nan_in",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[8]  = '{"neg",        32'hBF800000, 32'h40400000, 32'hC0400000, 4'b0000};
        vecs[9]  = '{"subn_flush", 32'h00000001, 32'h40000000, 32'h00000000, 4'b0000};
        vecs[10] = '{"norm_shift", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};
        vecs[11] = '{"tie_up",     32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
        vecs[12] = '{"tie_even",   32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
        vecs[13] = '{"rnd_carry",  32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001};
        vecs[14] = '{"max_finite", 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000};

        rst = 1'b1;
        start0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check("rst busy",  32'(busy0), 32'd0);
        check("rst done",  32'(done0), 32'd0);
        check("rst c",     c0, 32'h0);
        check("rst flags", 32'(flags0), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Each op starts on the done-cycle negedge of the previous one, so these run back-to-back.
        for (int i = 0; i < 15; i++) begin
            run_op(1'b0, vecs[i].name, vecs[i].a, vecs[i].b, 27, 1'b0, rc, rf);
            check({vecs[i].name, " c"}, rc, vecs[i].c);
            check({vecs[i].name, " flags"}, 32'(rf), 32'(vecs[i].f));
        end

        run_op(1'b0, "ignore_start", 32'h3FC00000, 32'h40000000, 27, 1'b1, rc, rf);
        check("ignore_start c", rc, 32'h40400000);
        check("ignore_start flags", 32'(rf), 32'h0);
        check("b2b in_done_cycle", 32'(done0), 32'd1);
        run_op(1'b0, "b2b", 32'h3F800001, 32'h3F800001, 27, 1'b0, rc, rf);
        check("b2b c", rc, 32'h3F800002);
        check("b2b flags", 32'(rf), 32'h1);

        @(negedge clk);
        start0 = 1'b1; a0 = 32'h3FC00000; b0 = 32'h40000000;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        start0 = 1'b1; a0 = 32'h40000000; b0 = 32'h40000000;
        @(negedge clk);
        rst = 1'b0;
        start0 = 1'b0;
        check("midrst busy",  32'(busy0), 32'd0);
        check("midrst done",  32'(done0), 32'd0);
        check("midrst c",     c0, 32'h0);
        check("midrst flags", 32'(flags0), 32'h0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done0) saw_done = 1'b1;
        end
        check("midrst no_done", 32'(saw_done), 32'd0);

        run_op(1'b0, "after_rst", 32'h3FC00000, 32'h40000000, 27, 1'b0, rc, rf);
        check("after_rst c", rc, 32'h40400000);
        check("after_rst flags", 32'(rf), 32'h0);

        @(negedge clk);
        run_op(1'b1, "h_basic", 32'h3E00, 32'h4000, 14, 1'b0, rc, rf);
        check("h_basic c", rc, 32'h4200);
        check("h_basic flags", 32'(rf), 32'h0);
        run_op(1'b1, "h_neg", 32'hBC00, 32'h4200, 14, 1'b0, rc, rf);
        check("h_neg c", rc, 32'hC200);
        check("h_neg flags", 32'(rf), 32'h0);
        run_op(1'b1, "h_ovf", 32'h7BFF, 32'h4000, 14, 1'b0, rc, rf);
        check("h_ovf c", rc, 32'h7C00);
        check("h_ovf flags", 32'(rf), 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
